// File: rtl/spell_mem_port.sv
// spell_mem_port: memory responder for the spell stack CPU (data regfile, code SRAM, IO)
// Optional feature macro: SPELL_MEM_CODE_WP_EN (code writes below WP_LIMIT are blocked, wp_fault pulses)
// Ports:
//   clock, reset                       rising-edge clock, async active-high reset
//   req_valid/ready/write/type/addr/wdata  single outstanding request (type: 0 None, 1 Data, 2 Code, 3 IO)
//   rsp_valid, rsp_rdata               one-cycle completion pulse and held read data
//   sram_addr/wdata/rdata/cs/we        byte-wide code SRAM, strobed for WAIT_CYCLES+1 cycles
//   io_out, io_in                      IO output register and sampled input pins
//   wp_fault                           blocked code write pulse (zero without the optional feature)
module spell_mem_port #(
  parameter int         DATA_WORDS  = 32,
  parameter int         WAIT_CYCLES = 1,
  parameter logic [7:0] WP_LIMIT    = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_type,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [7:0] sram_addr,
  output logic [7:0] sram_wdata,
  input  logic [7:0] sram_rdata,
  output logic       sram_cs,
  output logic       sram_we,
  output logic [7:0] io_out,
  input  logic [7:0] io_in,
  output logic       wp_fault
);
  localparam int AW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
`ifdef SPELL_MEM_CODE_WP_EN
  localparam logic WP_EN = 1'b1;
`else
  localparam logic WP_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t          r_state, w_next;
  logic [3:0]      r_cnt;
  logic            r_write, r_wp_fault;
  logic [7:0]      r_rdata, r_sram_addr, r_sram_wdata, r_io_out;
  logic [7:0]      r_mem [DATA_WORDS];
  logic            w_accept, w_code, w_wp_block, w_to_bus;
  logic [AW-1:0]   w_idx;
  assign w_accept   = req_valid && (r_state == IDLE);
  assign w_code     = req_type == 2'd2;
  // WP_EN folds to a constant, so without the feature this is always 0
  assign w_wp_block = WP_EN && req_write && (req_addr < WP_LIMIT);
  assign w_to_bus   = w_code && !w_wp_block;
  // upper address bits are ignored: the data space wraps every DATA_WORDS bytes
  assign w_idx      = req_addr[AW-1:0];
  always_ff @(posedge clock or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = IDLE;
    w_next = (r_state == IDLE) ? (w_accept ? (w_to_bus ? BUS : RESP) : IDLE) :
             (r_state == BUS)  ? ((r_cnt == 4'd0) ? RESP : BUS) : IDLE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_cnt        <= 4'd0;
      r_write      <= 1'b0;
      r_wp_fault   <= 1'b0;
      r_rdata      <= 8'h00;
      r_sram_addr  <= 8'h00;
      r_sram_wdata <= 8'h00;
      r_io_out     <= 8'h00;
    end else begin
      r_wp_fault <= w_accept && w_code && w_wp_block;
      if (w_accept) begin
        r_cnt <= 4'(WAIT_CYCLES);
        // SRAM address/data only move on code accepts so they hold between accesses
        if (w_to_bus) begin
          r_write      <= req_write;
          r_sram_addr  <= req_addr;
          r_sram_wdata <= req_wdata;
        end else
          r_rdata <= req_write ? 8'h00 :
                     (req_type == 2'd1) ? r_mem[w_idx] :
                     (req_type == 2'd3) ? io_in : 8'h00;
        if (req_write && req_type == 2'd3) r_io_out <= req_wdata;
      end else if (r_state == BUS) begin
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd0) r_rdata <= r_write ? 8'h00 : sram_rdata;
      end
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < DATA_WORDS; i++) r_mem[i] <= 8'h00;
    end else if (w_accept && req_write && req_type == 2'd1)
      r_mem[w_idx] <= req_wdata;
  assign req_ready  = r_state == IDLE;
  assign rsp_valid  = r_state == RESP;
  assign rsp_rdata  = r_rdata;
  assign sram_cs    = r_state == BUS;
  assign sram_we    = (r_state == BUS) && r_write;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
  assign io_out     = r_io_out;
  assign wp_fault   = r_wp_fault;
endmodule

// File: tb/tb_spell_mem_port.sv
// tb_spell_mem_port: randomized self-checking bench for spell_mem_port against a behavioural model
module tb_spell_mem_port;
  localparam int         DW  = 32;
  localparam int         WC  = 2;
  localparam logic [7:0] WPL = 8'h20;
`ifdef SPELL_MEM_CODE_WP_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif
  logic       clock = 1'b0, reset = 1'b1;
  logic       req_valid = 1'b0, req_write = 1'b0;
  logic [1:0] req_type = 2'd0;
  logic [7:0] req_addr = 8'h00, req_wdata = 8'h00, io_in = 8'h00;
  logic       req_ready, rsp_valid, sram_cs, sram_we, wp_fault;
  logic [7:0] rsp_rdata, sram_addr, sram_wdata, sram_rdata, io_out;
  logic [7:0] sram_mem [256];
  logic       pre_en = 1'b0;
  logic [7:0] pre_a = 8'h00, pre_d = 8'h00;
  logic [7:0] mem_m [DW];
  logic [7:0] code_m [256];
  logic [7:0] io_m;
  int         n_cmp = 0, n_fail = 0;
  int         o_lat, o_cs, o_we;
  logic [7:0] o_rdata;
  logic       o_wpf, o_rdy, o_abad, o_dbad;

  spell_mem_port #(.DATA_WORDS(DW), .WAIT_CYCLES(WC), .WP_LIMIT(WPL)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_cs(sram_cs), .sram_we(sram_we), .io_out(io_out),
    .io_in(io_in), .wp_fault(wp_fault));

  always #5 clock = ~clock;

  always @(posedge clock)
    if (pre_en) sram_mem[pre_a] <= pre_d;
    else if (sram_cs && sram_we) sram_mem[sram_addr] <= sram_wdata;
  assign sram_rdata = sram_mem[sram_addr];

  task automatic do_req(input logic w, input logic [1:0] t, input logic [7:0] a, input logic [7:0] d);
    int g;
    @(negedge clock);
    req_valid = 1'b1; req_write = w; req_type = t; req_addr = a; req_wdata = d;
    g = 0;
    while (!req_ready && g < 50) begin @(negedge clock); g++; end
    @(posedge clock);
    #1 req_valid = 1'b0;
    o_lat = -1; o_cs = 0; o_we = 0; o_abad = 0; o_dbad = 0; o_wpf = 0; o_rdy = 1; o_rdata = 8'h00;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (sram_cs) begin
        o_cs++;
        if (sram_we) o_we++;
        if (sram_addr !== a) o_abad = 1'b1;
        if (sram_wdata !== d) o_dbad = 1'b1;
      end
      if (rsp_valid) begin
        o_lat = k; o_rdata = rsp_rdata; o_wpf = wp_fault; o_rdy = req_ready;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pre_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clock);
      pre_a = 8'(i); pre_d = 8'($urandom); code_m[i] = pre_d;
    end
    @(negedge clock);
    pre_en = 1'b0;
    for (int i = 0; i < DW; i++) mem_m[i] = 8'h00;
    io_m = 8'h00;
    @(negedge clock);
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_rdata, sram_cs, sram_we, sram_addr, sram_wdata, io_out, wp_fault} !==
        {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b rsp=%b rd=%h cs=%b we=%b sa=%h sw=%h io=%h wpf=%b, want 1 0 00 0 0 00 00 00 0",
               req_ready, rsp_valid, rsp_rdata, sram_cs, sram_we, sram_addr, sram_wdata, io_out, wp_fault);
    end
    reset = 1'b0;
  endtask

  task automatic test_data_wrap();
    do_req(1'b1, 2'd1, 8'h25, 8'hA5);
    mem_m[5] = 8'hA5;
    n_cmp++;
    if (o_lat !== 1) begin n_fail++; $display("FAIL data_wr_lat: got %0d want 1", o_lat); end
    do_req(1'b0, 2'd1, 8'h05, 8'h00);
    n_cmp++;
    if (o_lat !== 1) begin n_fail++; $display("FAIL data_rd_lat: got %0d want 1", o_lat); end
    n_cmp++;
    if (o_rdata !== 8'hA5) begin n_fail++; $display("FAIL data_wrap_rd: got %h want a5", o_rdata); end
  endtask

  task automatic test_code_read();
    do_req(1'b1, 2'd2, 8'h40, 8'h3C);
    code_m[8'h40] = 8'h3C;
    do_req(1'b0, 2'd2, 8'h40, 8'h00);
    n_cmp++;
    if (o_cs !== WC + 1 || o_we !== 0 || o_abad) begin
      n_fail++; $display("FAIL code_rd_bus: cs=%0d we=%0d abad=%b want cs=%0d we=0 abad=0", o_cs, o_we, o_abad, WC + 1);
    end
    n_cmp++;
    if (o_lat !== WC + 2) begin n_fail++; $display("FAIL code_rd_lat: got %0d want %0d", o_lat, WC + 2); end
    n_cmp++;
    if (o_rdata !== 8'h3C) begin n_fail++; $display("FAIL code_rd_data: got %h want 3c", o_rdata); end
  endtask

  task automatic test_code_write();
    do_req(1'b1, 2'd2, 8'h10, 8'h77);
    if (!WP_ON) code_m[8'h10] = 8'h77;
    n_cmp++;
    if (o_cs !== (WP_ON ? 0 : WC + 1) || o_we !== o_cs || o_dbad || o_abad) begin
      n_fail++; $display("FAIL code_wr_bus: cs=%0d we=%0d dbad=%b abad=%b want cs=we=%0d", o_cs, o_we, o_dbad, o_abad,
                         WP_ON ? 0 : WC + 1);
    end
    n_cmp++;
    if (o_lat !== (WP_ON ? 1 : WC + 2) || o_wpf !== WP_ON || o_rdata !== 8'h00) begin
      n_fail++; $display("FAIL code_wr_rsp: lat=%0d wpf=%b rd=%h want lat=%0d wpf=%b rd=00", o_lat, o_wpf, o_rdata,
                         WP_ON ? 1 : WC + 2, WP_ON);
    end
    do_req(1'b1, 2'd2, 8'h20, 8'h99);
    code_m[8'h20] = 8'h99;
    n_cmp++;
    if (o_cs !== WC + 1 || o_we !== WC + 1 || o_lat !== WC + 2 || o_wpf !== 1'b0) begin
      n_fail++; $display("FAIL code_wr_limit: cs=%0d we=%0d lat=%0d wpf=%b want %0d %0d %0d 0", o_cs, o_we, o_lat, o_wpf,
                         WC + 1, WC + 1, WC + 2);
    end
    do_req(1'b0, 2'd2, 8'h10, 8'h00);
    n_cmp++;
    if (o_rdata !== code_m[8'h10]) begin n_fail++; $display("FAIL code_wr_readback: got %h want %h", o_rdata, code_m[8'h10]); end
  endtask

  task automatic test_io();
    do_req(1'b1, 2'd3, 8'h00, 8'h5A);
    io_m = 8'h5A;
    n_cmp++;
    if (o_lat !== 1 || io_out !== 8'h5A) begin n_fail++; $display("FAIL io_wr: lat=%0d io_out=%h want 1 5a", o_lat, io_out); end
    req_valid = 1'b1; req_write = 1'b1; req_type = 2'd3; req_wdata = 8'hFF;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (rsp_valid !== 1'b0 || io_out !== 8'h5A) begin
      n_fail++; $display("FAIL io_busy_ignored: rsp=%b io_out=%h want 0 5a", rsp_valid, io_out);
    end
    io_in = 8'hC3;
    do_req(1'b0, 2'd3, 8'h00, 8'h00);
    n_cmp++;
    if (o_rdata !== 8'hC3 || o_lat !== 1) begin n_fail++; $display("FAIL io_rd: rd=%h lat=%0d want c3 1", o_rdata, o_lat); end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_type = 2'd2; req_addr = 8'h80; req_wdata = 8'h11;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    n_cmp++;
    if ({sram_cs, sram_we} !== 2'b11) begin n_fail++; $display("FAIL midreset_bus: cs/we=%b want 11", {sram_cs, sram_we}); end
    code_m[8'h80] = 8'h11;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({sram_cs, sram_we, rsp_valid, req_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL midreset_async: cs,we,rsp,ready=%b want 0001", {sram_cs, sram_we, rsp_valid, req_ready});
    end
    for (int i = 0; i < DW; i++) mem_m[i] = 8'h00;
    io_m = 8'h00;
    seen = 0;
    repeat (2) begin @(negedge clock); if (rsp_valid) seen++; end
    reset = 1'b0;
    repeat (5) begin @(negedge clock); if (rsp_valid) seen++; end
    n_cmp++;
    if (seen !== 0 || req_ready !== 1'b1 || io_out !== 8'h00) begin
      n_fail++; $display("FAIL midreset_after: rsp_seen=%0d ready=%b io_out=%h want 0 1 00", seen, req_ready, io_out);
    end
    do_req(1'b0, 2'd1, 8'h05, 8'h00);
    n_cmp++;
    if (o_rdata !== 8'h00) begin n_fail++; $display("FAIL midreset_mem_clear: got %h want 00", o_rdata); end
  endtask

  task automatic test_random();
    logic       w, blk;
    logic [1:0] t;
    logic [7:0] a, d, exp_rd;
    int         exp_lat, exp_cs;
    for (int n = 0; n < 80; n++) begin
      t = 2'($urandom_range(0, 3)); w = 1'($urandom); a = 8'($urandom); d = 8'($urandom); io_in = 8'($urandom);
      if (n % 4 == 0) a = 8'($urandom_range(0, 63));
      blk = WP_ON && t == 2'd2 && w && (a < WPL);
      exp_lat = (t == 2'd2 && !blk) ? WC + 2 : 1;
      exp_cs  = (t == 2'd2 && !blk) ? WC + 1 : 0;
      exp_rd  = w ? 8'h00 : (t == 2'd1) ? mem_m[int'(a) % DW] : (t == 2'd2) ? code_m[a] : (t == 2'd3) ? io_in : 8'h00;
      do_req(w, t, a, d);
      if (w && t == 2'd1) mem_m[int'(a) % DW] = d;
      if (w && t == 2'd3) io_m = d;
      if (w && t == 2'd2 && !blk) code_m[a] = d;
      n_cmp++;
      if (o_lat !== exp_lat || o_rdata !== exp_rd || o_wpf !== blk || o_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_rsp[%0d] t=%0d w=%b a=%h: lat=%0d rd=%h wpf=%b rdy=%b want lat=%0d rd=%h wpf=%b rdy=0",
                 n, t, w, a, o_lat, o_rdata, o_wpf, o_rdy, exp_lat, exp_rd, blk);
      end
      n_cmp++;
      if (o_cs !== exp_cs || o_we !== (w ? exp_cs : 0) || o_abad || o_dbad || io_out !== io_m) begin
        n_fail++;
        $display("FAIL rand_side[%0d] t=%0d w=%b a=%h: cs=%0d we=%0d abad=%b dbad=%b io=%h want cs=%0d we=%0d io=%h",
                 n, t, w, a, o_cs, o_we, o_abad, o_dbad, io_out, exp_cs, w ? exp_cs : 0, io_m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_data_wrap();
    test_code_read();
    test_code_write();
    test_io();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/spell_mem_port.md
Name: spell_mem_port

Overview:
- Memory responder for the spell stack CPU.
- Accepts one read or write request at a time from the execute/control path and returns a completion.
- Services three spaces:
  - Data: internal byte register file.
  - Code: external byte-wide SRAM with programmable wait states.
  - IO: single output register plus input pins.
- Sits between the core sequencer and the chip's code-SRAM pins. It is the far end of the execute unit's memory_write_type / addr / data outputs and the source of its memory_input.

Parameters:
- DATA_WORDS, 32, data register-file depth in bytes; power of two, 2..256.
- WAIT_CYCLES, 1, extra SRAM strobe cycles per code access; 0..15.
- WP_LIMIT, 8'h00, code addresses below this value are write-protected (used only with the optional feature).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  port can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_type  in  2  address space: 0 None, 1 Data, 2 Code, 3 IO (shared memtypes encoding).
- req_addr  in  8  byte address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read data; valid only while rsp_valid is high.
- sram_addr  out  8  code SRAM address.
- sram_wdata  out  8  code SRAM write data.
- sram_rdata  in  8  code SRAM read data.
- sram_cs  out  1  code SRAM chip select, active-high.
- sram_we  out  1  code SRAM write enable, active-high.
- io_out  out  8  IO output register.
- io_in  in  8  IO input pins, sampled on read.
- wp_fault  out  1  one-cycle pulse on a blocked code write (optional feature only).

Behaviour:
- Reset, asynchronous and effective immediately, also when asserted mid-access:
  - FSM goes to IDLE.
  - req_ready=1, rsp_valid=0, rsp_rdata=0.
  - sram_cs=0, sram_we=0, sram_addr=0, sram_wdata=0.
  - io_out=0, wp_fault=0.
  - All data words cleared to 0.
  - An interrupted SRAM access is abandoned without a response.
- FSM states: IDLE, BUS, RESP.
  - req_ready=1 only in IDLE.
  - A request is accepted on a clock edge where req_valid && req_ready. Address, data, type and direction are latched on that edge.
- Data, IO and None requests: IDLE -> RESP. rsp_valid is high in the cycle after acceptance (latency 1).
  - Data write: mem[req_addr mod DATA_WORDS] <= wdata on the accept edge. Upper address bits are ignored (wrap-around).
  - Data read: rsp_rdata = mem[addr mod DATA_WORDS], registered at the accept edge. A write and a following read of the same address in consecutive requests returns the new value.
  - IO write: io_out <= wdata on the accept edge. IO read: rsp_rdata = io_in sampled on the accept edge.
  - None: no side effects; rsp_rdata=0.
- Code requests: IDLE -> BUS for exactly WAIT_CYCLES+1 cycles -> RESP.
  - During BUS:
    - sram_cs=1.
    - sram_addr=latched address.
    - sram_wdata=latched data.
    - sram_we=req_write.
  - On the final BUS edge, rsp_rdata <= sram_rdata for reads, or 0 for writes.
  - Outside BUS: sram_cs=0, sram_we=0; address and data hold their last values.
  - rsp_valid is asserted WAIT_CYCLES+2 cycles after acceptance.
- RESP lasts exactly one cycle and then returns to IDLE.
  - req_ready=0 during RESP, so the minimum request spacing is 2 cycles for Data/IO/None and WAIT_CYCLES+3 cycles for Code.
  - rsp_rdata holds its value until the next response.
- req_valid while busy is ignored (not queued); the requester must hold it until accepted.
- Write responses still pulse rsp_valid.

Optional Feature:
- Macro: SPELL_MEM_CODE_WP_EN.
- Defined:
  - A code write with addr < WP_LIMIT skips BUS entirely: IDLE -> RESP, with no sram_cs/sram_we activity.
  - wp_fault pulses high in the same cycle as rsp_valid; rsp_rdata=0.
  - Code reads are unaffected.
- Undefined:
  - wp_fault is tied to 0.
  - WP_LIMIT is unused; all code writes reach the SRAM.

Test Plan:
- Reset mid code access (WAIT_CYCLES=3, assert reset in the 2nd BUS cycle) -> sram_cs=0 and sram_we=0 immediately, no rsp_valid, req_ready=1 after reset release.
- Data write addr 8'h25 data 8'hA5, then data read addr 8'h05 (DATA_WORDS=32) -> read returns 8'hA5 (wrap); each rsp_valid arrives 1 cycle after accept.
- Code read addr 8'h40 with sram_rdata=8'h3C, WAIT_CYCLES=2 -> sram_cs high for exactly 3 cycles with sram_addr=8'h40 and sram_we=0; rsp_valid 4 cycles after accept; rsp_rdata=8'h3C.
- Code write addr 8'h10 data 8'h77, WAIT_CYCLES=0 -> one cycle with sram_cs=1, sram_we=1, sram_wdata=8'h77; rsp_valid 2 cycles after accept.
- IO write 8'h5A then IO read with io_in=8'hC3 -> io_out=8'h5A; rsp_rdata=8'hC3; req_valid held during RESP is not accepted until IDLE.
- With SPELL_MEM_CODE_WP_EN and WP_LIMIT=8'h20, code write addr 8'h1F -> no sram_cs; wp_fault and rsp_valid pulse 1 cycle after accept. A write to addr 8'h20 proceeds normally.
